// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: round-robin arbiter sharing one Fibonacci LFSR between NUM_REQ requesters
// Optional reseed ports enabled by defining LFSR_RESEED_EN.
module lfsr_rng_arbiter #(
  parameter int WIDTH = 4,
  parameter int NUM_REQ = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter logic [WIDTH-1:0] SEED = 4'b0001,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
`ifdef LFSR_RESEED_EN
  input  logic               seed_load_i,
  input  logic [WIDTH-1:0]   seed_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [WIDTH-1:0]   rnd_o,
  output logic               ready_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = WARMUP_CYCLES > 1 ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] lfsr, lfsr_step, reload_val;
  logic [PW-1:0] rr_ptr, win;
  logic [CW-1:0] cnt;
  logic reload, any, warm_last;
`ifdef LFSR_RESEED_EN
  assign reload = seed_load_i;
  assign reload_val = seed_i == '0 ? SEED : seed_i;
`else
  assign reload = 1'b0;
  assign reload_val = SEED;
`endif
  // an all-zero register would lock up, so it restarts from SEED
  assign lfsr_step = lfsr == '0 ? SEED : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign any = |req_i;
  assign warm_last = int'(cnt) + 1 >= WARMUP_CYCLES;
  // lowest offset from rr_ptr wins, so scan downwards and let the last hit stand
  always_comb begin
    win = rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_i[(int'(rr_ptr) + i) % NUM_REQ]) win = PW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WARMUP_CYCLES == 0 ? IDLE : WARMUP;
      lfsr <= SEED;
      rr_ptr <= PW'(NUM_REQ - 1);
      cnt <= '0;
      gnt_o <= '0;
      rnd_o <= '0;
      ready_o <= 1'b0;
    end else if (reload) begin
      lfsr <= reload_val;
      gnt_o <= '0;
    end else if (state == WARMUP) begin
      lfsr <= lfsr_step;
      cnt <= cnt + 1'b1;
      gnt_o <= '0;
      if (warm_last) begin
        state <= IDLE;
        ready_o <= 1'b1;
      end
    end else if (any) begin
      gnt_o <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
      rnd_o <= lfsr;
      lfsr <= lfsr_step;
      rr_ptr <= win;
      state <= ACTIVE;
      ready_o <= 1'b1;
    end else begin
      gnt_o <= '0;
      state <= IDLE;
      ready_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: randomized bench against a behavioural arbiter/LFSR model
module tb_lfsr_rng_arbiter;
  localparam int WU = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt_o, rnd_o;
  logic ready_o;
  int checks = 0;
  int failures = 0;
  int m_lfsr, m_ptr, m_warm;
  logic [3:0] m_gnt, m_rnd;
  bit m_ready;
  always #5 clk = ~clk;
  lfsr_rng_arbiter dut (
    .clk(clk),
    .reset(reset),
    .req_i(req),
`ifdef LFSR_RESEED_EN
    .seed_load_i(1'b0),
    .seed_i(4'b0000),
`endif
    .gnt_o(gnt_o),
    .rnd_o(rnd_o),
    .ready_o(ready_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int nxt(input int l);
    if (l == 0) return 1;
    return ((l << 1) & 15) | (((l >> 3) ^ (l >> 2)) & 1);
  endfunction
  task automatic model_reset();
    m_lfsr = 1;
    m_ptr = 3;
    m_warm = 0;
    m_gnt = '0;
    m_rnd = '0;
    m_ready = 0;
  endtask
  task automatic model_edge(input logic [3:0] r);
    m_gnt = '0;
    if (m_warm < WU) begin
      m_lfsr = nxt(m_lfsr);
      m_warm++;
      m_ready = (m_warm == WU);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (r[idx] && m_gnt == 0) begin
          m_gnt = 4'(1 << idx);
          m_ptr = idx;
          m_rnd = 4'(m_lfsr);
          m_lfsr = nxt(m_lfsr);
        end
      end
    end
  endtask
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("gnt", gnt_o, m_gnt);
    check("rnd", rnd_o, m_rnd);
    check("ready", ready_o, m_ready);
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check("rst_gnt", gnt_o, 0);
    check("rst_rnd", rnd_o, 0);
    check("rst_ready", ready_o, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic warmup_seq();
    for (int i = 0; i < WU; i++) cycle(4'b0000);
    check("warm_ready", ready_o, 1);
    check("warm_lfsr", dut.lfsr, 4'b0011);
  endtask
  initial begin
    logic [15:0] seen;
    int distinct;
    model_reset();
    #12;
    check("rst_gnt", gnt_o, 0);
    check("rst_ready", ready_o, 0);
    @(negedge clk);
    reset = 1'b1;
    warmup_seq();
    cycle(4'b0001);
    check("t2_rnd0", rnd_o, 4'b0011);
    cycle(4'b0001);
    check("t2_rnd1", rnd_o, 4'b0110);
    cycle(4'b0001);
    check("t2_rnd2", rnd_o, 4'b1101);
    seen = '0;
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(4'b1111);
      if (!seen[rnd_o]) distinct++;
      seen[rnd_o] = 1'b1;
    end
    check("t3_distinct", distinct, 15);
    cycle(4'b1010);
    cycle(4'b1010);
    cycle(4'b0000);
    check("t4_idle_gnt", gnt_o, 0);
    cycle(4'b1111);
    cycle(4'b1111);
    #2;
    pulse_reset();
    warmup_seq();
    cycle(4'b0001);
    check("t5_rnd0", rnd_o, 4'b0011);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        @(posedge clk);
        model_edge(req);
        #3;
        pulse_reset();
      end else begin
        cycle(4'($urandom_range(0, 15)));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
